mipse_core: RTL and testbench
=============================

# mipse_core

Single-cycle 32-bit MIPS integer core (module `mipse`), the CPU of the system-level simulation model. It fetches one instruction per clock from an external instruction memory (`imem`) and executes it completely in that cycle. It reads and writes an external data memory (`dmem`) through a combinational address/data interface. Program termination is a software convention: a store to address 0x0000_7fff, which the system bench detects on `memwrite`.

## Interface
- `DATA_W` — default 32 — datapath width; from the shared defines.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset (`ENABLE_N`=0, `DISABLE_N`=1).
- `instr`  in  32  — instruction word at `pc`; `imem` is combinational, indexed by `pc[17:2]`.
- `readdata`  in  32  — `dmem` combinational read data at `aluresult[17:2]`.
- `pc`  out  32  — current program counter.
- `aluresult`  out  32  — ALU output; doubles as data address.
- `writedata`  out  32  — store data (the rt register value).
- `memwrite`  out  1  — 1 during a `sw`; `dmem` writes on the rising edge of `clk`.

## Operation
- Register file: 32×32, two combinational read ports, one write port written on `posedge clk`. r0 reads 0 and writes to it are discarded.
- Decode fields: op [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0].
- R-type instructions (op=0), by funct:
  - 0x20/0x21 add/addu, 0x22/0x23 sub/subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2a slt (signed), 0x2b sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra. These shift rt by shamt.
  - 0x08 jr.
  - Result is written to rd.
- I-type instructions, result written to rt:
  - addi/addiu 0x08/0x09 and slti 0x0a use the sign-extended immediate.
  - andi 0x0c, ori 0x0d, xori 0x0e use the zero-extended immediate.
  - lui 0x0f yields {imm, 16'h0}.
- lw 0x23: rt ← `readdata`; address = rs + sext(imm).
- sw 0x2b: `memwrite`=1, `writedata`=rt, address = rs + sext(imm).
- beq 0x04 / bne 0x05: if the condition holds, next pc = pc+4 + (sext(imm)<<2).
- j 0x02: next pc = {pc+4[31:28], instr[25:0], 2'b00}. jal 0x03 does the same and also sets r31 ← pc+4.
- All other instructions: next pc = pc+4.
- No overflow traps, no delay slots, no alignment checks. Addresses pass through unmodified, so an unaligned address such as 0x7fff is legal.
- Unknown opcodes and functs behave as NOP: no register write, `memwrite`=0, pc+4.

## Timing
- Reset (asserted asynchronously): `pc`=0 and all registers = 0 immediately. Other outputs are combinational from `instr` and the register values.
- One instruction per cycle, latency 1: register, pc and memory updates all occur on the same rising edge.
- Outputs settle before the falling edge; the bench samples at negedge.
- Reset deasserted mid-cycle: the first fetch is at pc 0 and the first update happens at the next rising edge.
- Reset asserted mid-program: pc and registers clear at once; memory contents are kept.
- lw followed by a dependent instruction needs no stall, because the write-back completes at the edge.

## Structure
- Shared defines file (`def.h`) holds:
  - `DATA_W`, `ENABLE`/`DISABLE`, `ENABLE_N`/`DISABLE_N`.
  - Opcode constants (`OP_RTYPE`, `OP_LW`, ...) and funct constants.
  - ALU-control encodings.
- Sub-module `rfile`, instantiated as `rfile_1`, with storage array `rf[0:31]`. These names are fixed because benches probe `mipse_1.rfile_1.rf[n]`.
- The ALU and decoder are inline in `mipse`.
- `imem` (64K words, combinational read) and `dmem` (64K words, array `mem`, combinational read, synchronous write when `we`=1) are separate simple models.

## Test plan
- Reset then `addi r1,r0,5`; `addi r2,r0,-3`; `add r3,r1,r2` → r1=5, r2=0xffff_fffd, r3=2; pc goes 0, 4, 8, 12.
- `sw r3,8(r0)` then `lw r4,8(r0)` → `memwrite`=1 with `aluresult`=8 and `writedata`=2 in the store cycle; `dmem` mem[2]=2; r4=2; `memwrite`=0 in the load cycle.
- `beq r1,r1,+2` at pc 0x10 → next pc 0x1c; `bne r1,r1,+2` → next pc 0x14; `j 0x40` → pc 0x100.
- `lui r5,0x1234`; `ori r5,r5,0x8000`; `slt r6,r2,r1` → r5=0x1234_8000, r6=1. `addi r0,r0,7` leaves r0=0.
- `jal` at pc 0x20 to 0x80 → r31=0x24 and pc=0x80; `jr r31` → pc 0x24.
- `addi r7,r0,0x7fff`; `sw r3,0(r7)` → `aluresult`=0x0000_7fff with `memwrite`=1, the termination condition. Asserting `rst_n`=0 mid-run clears pc and r1–r31 asynchronously.

Source files
------------

// File: rtl/mipse_core_pkg.sv
// Shared constants for the single-cycle MIPS core: widths, enable levels,
// opcode/funct encodings and ALU control codes.
package mipse_core_pkg;

    localparam int DATA_W = 32;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_ctl_e;

    typedef enum logic [1:0] {
        SRC_RT, SRC_SEXT, SRC_ZEXT
    } src_b_e;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mipse_core_rfile.sv
// 32x32 register file: two combinational read ports, one write port on the
// rising edge. r0 is hard-wired to zero; the whole array clears on reset.
module mipse_core_rfile
    import mipse_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        i_ra1,
    input  logic [4:0]        i_ra2,
    input  logic              i_we,
    input  logic [4:0]        i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    // Array name is fixed: system benches probe rfile_1.rf[n] directly.
    logic [DATA_W-1:0] rf [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == ENABLE_N) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            rf[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : rf[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : rf[i_ra2];

endmodule

// File: rtl/mipse_core.sv
// Single-cycle MIPS integer core: fetch, decode, ALU, memory access and
// write-back all complete within one clock; only pc and the register file hold state.
module mipse_core
    import mipse_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] readdata,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] aluresult,
    output logic [DATA_W-1:0] writedata,
    output logic              memwrite
);

    logic [31:0]       r_pc;
    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_shamt, w_wa;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_rd1, w_rd2, w_imm_sext, w_src_b, w_wd;
    logic [31:0]       w_pc_plus4, w_br_target, w_pc_next;
    alu_ctl_e          w_alu_ctl;
    src_b_e            w_src_sel;
    logic              w_reg_we, w_mem_to_reg, w_branch, w_bne, w_jump, w_jal, w_jr;

    assign w_op       = instr[31:26];
    assign w_rs       = instr[25:21];
    assign w_rt       = instr[20:16];
    assign w_rd       = instr[15:11];
    assign w_shamt    = instr[10:6];
    assign w_funct    = instr[5:0];
    assign w_imm      = instr[15:0];
    assign w_imm_sext = sext16(w_imm);

    mipse_core_rfile rfile_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_we  (w_reg_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_comb begin
        w_alu_ctl    = ALU_ADD;
        w_src_sel    = SRC_RT;
        w_reg_we     = DISABLE;
        w_wa         = w_rt;
        w_mem_to_reg = DISABLE;
        memwrite     = DISABLE;
        w_branch     = DISABLE;
        w_bne        = DISABLE;
        w_jump       = DISABLE;
        w_jal        = DISABLE;
        w_jr         = DISABLE;
        case (w_op)
            OP_RTYPE: begin
                w_wa     = w_rd;
                w_reg_we = ENABLE;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_alu_ctl = ALU_ADD;
                    FN_SUB, FN_SUBU: w_alu_ctl = ALU_SUB;
                    FN_AND:          w_alu_ctl = ALU_AND;
                    FN_OR:           w_alu_ctl = ALU_OR;
                    FN_XOR:          w_alu_ctl = ALU_XOR;
                    FN_NOR:          w_alu_ctl = ALU_NOR;
                    FN_SLT:          w_alu_ctl = ALU_SLT;
                    FN_SLTU:         w_alu_ctl = ALU_SLTU;
                    FN_SLL:          w_alu_ctl = ALU_SLL;
                    FN_SRL:          w_alu_ctl = ALU_SRL;
                    FN_SRA:          w_alu_ctl = ALU_SRA;
                    FN_JR: begin
                        w_reg_we = DISABLE;
                        w_jr     = ENABLE;
                    end
                    default:         w_reg_we = DISABLE;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_src_sel = SRC_SEXT;
                w_reg_we  = ENABLE;
            end
            OP_SLTI: begin
                w_src_sel = SRC_SEXT;
                w_alu_ctl = ALU_SLT;
                w_reg_we  = ENABLE;
            end
            OP_ANDI: begin
                w_src_sel = SRC_ZEXT;
                w_alu_ctl = ALU_AND;
                w_reg_we  = ENABLE;
            end
            OP_ORI: begin
                w_src_sel = SRC_ZEXT;
                w_alu_ctl = ALU_OR;
                w_reg_we  = ENABLE;
            end
            OP_XORI: begin
                w_src_sel = SRC_ZEXT;
                w_alu_ctl = ALU_XOR;
                w_reg_we  = ENABLE;
            end
            OP_LUI: begin
                w_alu_ctl = ALU_LUI;
                w_reg_we  = ENABLE;
            end
            OP_LW: begin
                w_src_sel    = SRC_SEXT;
                w_reg_we     = ENABLE;
                w_mem_to_reg = ENABLE;
            end
            OP_SW: begin
                w_src_sel = SRC_SEXT;
                memwrite  = ENABLE;
            end
            OP_BEQ: begin
                w_alu_ctl = ALU_SUB;
                w_branch  = ENABLE;
            end
            OP_BNE: begin
                w_alu_ctl = ALU_SUB;
                w_branch  = ENABLE;
                w_bne     = ENABLE;
            end
            OP_J:   w_jump = ENABLE;
            OP_JAL: begin
                w_jump   = ENABLE;
                w_jal    = ENABLE;
                w_reg_we = ENABLE;
                w_wa     = 5'd31;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_src_sel)
            SRC_SEXT: w_src_b = w_imm_sext;
            SRC_ZEXT: w_src_b = {{(DATA_W-16){1'b0}}, w_imm};
            default:  w_src_b = w_rd2;
        endcase
    end

    // Shifts operate on rt (always the b operand for R-type) by shamt.
    always_comb begin
        case (w_alu_ctl)
            ALU_SUB:  aluresult = w_rd1 - w_src_b;
            ALU_AND:  aluresult = w_rd1 & w_src_b;
            ALU_OR:   aluresult = w_rd1 | w_src_b;
            ALU_XOR:  aluresult = w_rd1 ^ w_src_b;
            ALU_NOR:  aluresult = ~(w_rd1 | w_src_b);
            ALU_SLT:  aluresult = {{(DATA_W-1){1'b0}}, $signed(w_rd1) < $signed(w_src_b)};
            ALU_SLTU: aluresult = {{(DATA_W-1){1'b0}}, w_rd1 < w_src_b};
            ALU_SLL:  aluresult = w_src_b << w_shamt;
            ALU_SRL:  aluresult = w_src_b >> w_shamt;
            ALU_SRA:  aluresult = $signed(w_src_b) >>> w_shamt;
            ALU_LUI:  aluresult = {w_imm, 16'h0000};
            default:  aluresult = w_rd1 + w_src_b;
        endcase
    end

    assign writedata = w_rd2;
    assign w_wd      = w_jal ? w_pc_plus4 : (w_mem_to_reg ? readdata : aluresult);

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jr)
            w_pc_next = w_rd1;
        else if (w_jump)
            w_pc_next = {w_pc_plus4[31:28], instr[25:0], 2'b00};
        else if (w_branch && ((w_rd1 == w_rd2) != w_bne))
            w_pc_next = w_br_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == ENABLE_N)
            r_pc <= '0;
        else
            r_pc <= w_pc_next;
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_mipse_core.sv
// Directed program bench for mipse_core with combinational imem/dmem models;
// per-cycle expected outputs flow through a scoreboard queue to a negedge monitor.
module tb_mipse_core;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        bit          ca;
        logic [31:0] wd;
        bit          cw;
        logic        mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr, readdata, pc, aluresult, writedata;
    logic        memwrite;

    logic [31:0] imem [0:65535];
    logic [31:0] dmem [0:65535];

    exp_t plan[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mipse_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .readdata  (readdata),
        .pc        (pc),
        .aluresult (aluresult),
        .writedata (writedata),
        .memwrite  (memwrite)
    );

    assign instr    = imem[pc[17:2]];
    assign readdata = dmem[aluresult[17:2]];

    always @(posedge clk) if (memwrite) dmem[aluresult[17:2]] <= writedata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] f_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        imem[addr[17:2]] = w;
    endtask

    task automatic add(input logic [31:0] p, input logic [31:0] a, input bit ca,
                       input logic [31:0] w, input bit cw, input logic m);
        exp_t e;
        e.pc = p; e.alu = a; e.ca = ca; e.wd = w; e.cw = cw; e.mw = m;
        plan.push_back(e);
    endtask

    task automatic chk_reg(input int n, input logic [31:0] exp);
        chk($sformatf("r%0d", n), dut.rfile_1.rf[n], exp);
    endtask

    // Monitor: the core presents a result every cycle; compare at negedge.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("pc@%h", e.pc), pc, e.pc);
            chk($sformatf("memwrite@%h", e.pc), {31'd0, memwrite}, {31'd0, e.mw});
            if (e.ca) chk($sformatf("aluresult@%h", e.pc), aluresult, e.alu);
            if (e.cw) chk($sformatf("writedata@%h", e.pc), writedata, e.wd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        put(32'h000, f_i(6'h08, 0, 1, 16'd5));          // addi r1,r0,5
        put(32'h004, f_i(6'h08, 0, 2, 16'hfffd));       // addi r2,r0,-3
        put(32'h008, f_r(1, 2, 3, 0, 6'h20));           // add r3,r1,r2
        put(32'h00c, f_i(6'h2b, 0, 3, 16'd8));          // sw r3,8(r0)
        put(32'h010, f_i(6'h23, 0, 4, 16'd8));          // lw r4,8(r0)
        put(32'h014, f_i(6'h04, 1, 1, 16'd2));          // beq r1,r1,+2
        put(32'h018, f_i(6'h08, 0, 9, 16'd1));          // skipped
        put(32'h01c, f_i(6'h08, 0, 9, 16'd2));          // skipped
        put(32'h020, f_i(6'h05, 1, 1, 16'd2));          // bne r1,r1,+2
        put(32'h024, f_j(6'h02, 26'h40));               // j 0x100
        put(32'h100, f_i(6'h0f, 0, 5, 16'h1234));       // lui r5
        put(32'h104, f_i(6'h0d, 5, 5, 16'h8000));       // ori r5,r5,0x8000
        put(32'h108, f_r(2, 1, 6, 0, 6'h2a));           // slt r6,r2,r1
        put(32'h10c, f_i(6'h08, 0, 0, 16'd7));          // addi r0,r0,7
        put(32'h110, f_j(6'h03, 26'h60));               // jal 0x180
        put(32'h180, f_r(31, 0, 0, 0, 6'h08));          // jr r31
        put(32'h114, f_r(1, 2, 8, 0, 6'h22));           // sub r8,r1,r2
        put(32'h118, f_r(1, 2, 10, 0, 6'h2b));          // sltu r10,r1,r2
        put(32'h11c, f_r(0, 2, 11, 1, 6'h03));          // sra r11,r2,1
        put(32'h120, f_r(0, 1, 12, 4, 6'h00));          // sll r12,r1,4
        put(32'h124, f_r(0, 2, 13, 28, 6'h02));         // srl r13,r2,28
        put(32'h128, f_r(1, 0, 14, 0, 6'h27));          // nor r14,r1,r0
        put(32'h12c, f_i(6'h0e, 1, 15, 16'hffff));      // xori r15,r1,0xffff
        put(32'h130, f_i(6'h0c, 2, 16, 16'hff00));      // andi r16,r2,0xff00
        put(32'h134, f_i(6'h0a, 2, 17, 16'hfffe));      // slti r17,r2,-2
        put(32'h138, f_i(6'h08, 0, 7, 16'h7fff));       // addi r7,r0,0x7fff
        put(32'h13c, f_i(6'h2b, 7, 3, 16'd0));          // sw r3,0(r7)
        put(32'h140, f_i(6'h23, 0, 18, 16'd8));         // lw r18,8(r0)
        put(32'h144, f_r(18, 1, 19, 0, 6'h20));         // add r19,r18,r1
        put(32'h148, f_i(6'h3f, 1, 20, 16'h1234));      // unknown opcode
        put(32'h14c, f_i(6'h04, 1, 2, 16'd3));          // beq r1,r2 not taken

        add(32'h000, 32'h5,        1, 32'h0,        1, 0);
        add(32'h004, 32'hfffffffd, 1, 32'h0,        1, 0);
        add(32'h008, 32'h2,        1, 32'hfffffffd, 1, 0);
        add(32'h00c, 32'h8,        1, 32'h2,        1, 1);
        add(32'h010, 32'h8,        1, 32'h0,        1, 0);
        add(32'h014, 32'h0,        0, 32'h0,        0, 0);
        add(32'h020, 32'h0,        0, 32'h0,        0, 0);
        add(32'h024, 32'h0,        0, 32'h0,        0, 0);
        add(32'h100, 32'h12340000, 1, 32'h0,        0, 0);
        add(32'h104, 32'h12348000, 1, 32'h0,        0, 0);
        add(32'h108, 32'h1,        1, 32'h0,        0, 0);
        add(32'h10c, 32'h7,        1, 32'h0,        0, 0);
        add(32'h110, 32'h0,        0, 32'h0,        0, 0);
        add(32'h180, 32'h0,        0, 32'h0,        0, 0);
        add(32'h114, 32'h8,        1, 32'h0,        0, 0);
        add(32'h118, 32'h1,        1, 32'h0,        0, 0);
        add(32'h11c, 32'hfffffffe, 1, 32'h0,        0, 0);
        add(32'h120, 32'h50,       1, 32'h0,        0, 0);
        add(32'h124, 32'hf,        1, 32'h0,        0, 0);
        add(32'h128, 32'hfffffffa, 1, 32'h0,        0, 0);
        add(32'h12c, 32'hfffa,     1, 32'h0,        0, 0);
        add(32'h130, 32'hff00,     1, 32'h0,        0, 0);
        add(32'h134, 32'h1,        1, 32'h0,        0, 0);
        add(32'h138, 32'h7fff,     1, 32'h0,        0, 0);
        add(32'h13c, 32'h7fff,     1, 32'h2,        1, 1);
        add(32'h140, 32'h8,        1, 32'h0,        0, 0);
        add(32'h144, 32'h7,        1, 32'h0,        0, 0);
        add(32'h148, 32'h0,        0, 32'h0,        0, 0);
        add(32'h14c, 32'h0,        0, 32'h0,        0, 0);
        add(32'h150, 32'h0,        1, 32'h0,        0, 0);

        #2;
        chk("reset pc", pc, 32'h0);
        chk("reset memwrite", {31'd0, memwrite}, 32'h0);
        for (int n = 0; n < 32; n++) chk_reg(n, 32'h0);

        @(posedge clk); #2;
        chk("pc held in reset", pc, 32'h0);
        rst_n = 1'b1;
        foreach (plan[i]) begin
            sbq.push_back(plan[i]);
            @(posedge clk); #2;
        end

        chk_reg(0, 32'h0);          chk_reg(1, 32'h5);
        chk_reg(2, 32'hfffffffd);   chk_reg(3, 32'h2);
        chk_reg(4, 32'h2);          chk_reg(5, 32'h12348000);
        chk_reg(6, 32'h1);          chk_reg(7, 32'h7fff);
        chk_reg(8, 32'h8);          chk_reg(9, 32'h0);
        chk_reg(10, 32'h1);         chk_reg(11, 32'hfffffffe);
        chk_reg(12, 32'h50);        chk_reg(13, 32'hf);
        chk_reg(14, 32'hfffffffa);  chk_reg(15, 32'hfffa);
        chk_reg(16, 32'hff00);      chk_reg(17, 32'h1);
        chk_reg(18, 32'h2);         chk_reg(19, 32'h7);
        chk_reg(20, 32'h0);         chk_reg(31, 32'h114);
        chk("dmem[2]", dmem[2], 32'h2);
        chk("dmem[0x1fff]", dmem[16'h1fff], 32'h2);
        chk("pc end of program", pc, 32'h154);

        rst_n = 1'b0;
        #1;
        chk("async reset pc", pc, 32'h0);
        chk_reg(1, 32'h0);
        chk_reg(31, 32'h0);
        chk("dmem kept over reset", dmem[2], 32'h2);

        @(posedge clk); #2;
        rst_n = 1'b1;
        add(32'h000, 32'h5,        1, 32'h0, 1, 0);
        add(32'h004, 32'hfffffffd, 1, 32'h0, 1, 0);
        sbq.push_back(plan[plan.size()-2]);
        @(posedge clk); #2;
        sbq.push_back(plan[plan.size()-1]);
        @(posedge clk); #2;
        chk_reg(1, 32'h5);
        chk_reg(2, 32'hfffffffd);
        @(negedge clk); #1;
        chk("scoreboard drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
